// File: rtl/time_set_editor_pkg.sv
// Shared definitions for the HH:MM:SS set-mode editor.
package time_set_editor_pkg;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned HR_W  = 5;
  localparam int unsigned MS_W  = 6;

  localparam logic [SEL_W-1:0] SEL_HR  = 3'b001;
  localparam logic [SEL_W-1:0] SEL_MIN = 3'b010;
  localparam logic [SEL_W-1:0] SEL_SEC = 3'b100;

  localparam logic [HR_W-1:0] HR_MAX = 5'd23;
  localparam logic [MS_W-1:0] MS_MAX = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_t;

  function automatic logic sel_valid(input logic [SEL_W-1:0] s);
    return (s == SEL_HR) || (s == SEL_MIN) || (s == SEL_SEC);
  endfunction

endpackage

// File: rtl/time_set_editor_field_step.sv
// Combinational +1/-1 step of one time field with wrap at 0 and limit.
module time_set_editor_field_step #(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] limit,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] value_c
);

  always_comb begin
    value_c = value;
    if (up) begin
      value_c = (value >= limit) ? '0 : value + W'(1);
    end else if (down) begin
      value_c = (value == '0) ? limit : value - W'(1);
    end
  end

endmodule

// File: rtl/time_set_editor.sv
// Set-mode editor for HH:MM:SS with field blink and load strobe.
// Auto-repeat on held buttons is enabled by defining TIME_SET_AUTOREPEAT_EN.
module time_set_editor
  import time_set_editor_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000,
  parameter int unsigned BLINK_HALF   = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel,
  input  logic             edit_en,
  input  logic             inc,
  input  logic             dec,
  input  logic [HR_W-1:0]  cur_h,
  input  logic [MS_W-1:0]  cur_m,
  input  logic [MS_W-1:0]  cur_s,
  output logic [HR_W-1:0]  set_h,
  output logic [MS_W-1:0]  set_m,
  output logic [MS_W-1:0]  set_s,
  output logic [SEL_W-1:0] blank,
  output logic             load
);

  localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);

  logic               edit_q, inc_q, dec_q;
  logic               edit_rise, edit_fall;
  logic               press_inc, press_dec, held, both;
  btn_state_t         state_q, state_d;
  logic               dir_q, dir_d;
  logic               btn_step, step_c, sel_ok;
  logic               step_up, step_dn;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               dark_q, dark_d;
  logic [HR_W-1:0]    h_c;
  logic [MS_W-1:0]    m_c, s_c;

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = (REPEAT_DELAY != 0) ^ (REPEAT_RATE != 0);
`endif

  assign edit_rise = edit_en & ~edit_q;
  assign edit_fall = ~edit_en & edit_q;
  assign both      = inc & dec;
  assign press_inc = inc & ~inc_q & ~dec;
  assign press_dec = dec & ~dec_q & ~inc;
  assign held      = dir_q ? dec : inc;
  assign sel_ok    = sel_valid(sel);

  // Button FSM: one step per press, optional timed repeat while held.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    btn_step = 1'b0;
`ifdef TIME_SET_AUTOREPEAT_EN
    rpt_cnt_d = rpt_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (press_inc || press_dec) begin
          btn_step = 1'b1;
          dir_d    = press_dec;
          state_d  = ST_HOLD;
`ifdef TIME_SET_AUTOREPEAT_EN
          rpt_cnt_d = '0;
`endif
        end
      end
      ST_HOLD: begin
        if (!held || both) begin
          state_d = ST_IDLE;
        end
`ifdef TIME_SET_AUTOREPEAT_EN
        else if (rpt_cnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
          btn_step  = 1'b1;
          state_d   = ST_REPEAT;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        end
`endif
      end
`ifdef TIME_SET_AUTOREPEAT_EN
      ST_REPEAT: begin
        if (!held || both) begin
          state_d = ST_IDLE;
        end else if (rpt_cnt_q == RPT_W'(REPEAT_RATE - 1)) begin
          btn_step  = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (!edit_en) state_d = ST_IDLE;
  end

  // Capture on entry wins over a coincident button step.
  assign step_c  = btn_step & edit_en & ~edit_rise & sel_ok;
  assign step_up = step_c & ~dir_d;
  assign step_dn = step_c & dir_d;

  time_set_editor_field_step #(.W(HR_W)) u_step_h (
    .value(set_h), .limit(HR_MAX),
    .up(step_up & (sel == SEL_HR)), .down(step_dn & (sel == SEL_HR)), .value_c(h_c)
  );
  time_set_editor_field_step #(.W(MS_W)) u_step_m (
    .value(set_m), .limit(MS_MAX),
    .up(step_up & (sel == SEL_MIN)), .down(step_dn & (sel == SEL_MIN)), .value_c(m_c)
  );
  time_set_editor_field_step #(.W(MS_W)) u_step_s (
    .value(set_s), .limit(MS_MAX),
    .up(step_up & (sel == SEL_SEC)), .down(step_dn & (sel == SEL_SEC)), .value_c(s_c)
  );

  // Blink timer restarts visible on every applied step.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    dark_d      = dark_q;
    if (!edit_en || step_c) begin
      blink_cnt_d = '0;
      dark_d      = 1'b0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
      blink_cnt_d = '0;
      dark_d      = ~dark_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edit_q      <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      state_q     <= ST_IDLE;
      dir_q       <= 1'b0;
      blink_cnt_q <= '0;
      dark_q      <= 1'b0;
      set_h       <= '0;
      set_m       <= '0;
      set_s       <= '0;
      blank       <= '0;
      load        <= 1'b0;
    end else begin
      edit_q      <= edit_en;
      inc_q       <= inc;
      dec_q       <= dec;
      state_q     <= state_d;
      dir_q       <= dir_d;
      blink_cnt_q <= blink_cnt_d;
      dark_q      <= dark_d;
      load        <= edit_fall;
      blank       <= (edit_en && dark_d && sel_ok) ? sel : '0;
      if (edit_rise) begin
        set_h <= cur_h;
        set_m <= cur_m;
        set_s <= cur_s;
      end else if (step_c) begin
        set_h <= h_c;
        set_m <= m_c;
        set_s <= s_c;
      end
    end
  end

`ifdef TIME_SET_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (reset) rpt_cnt_q <= '0;
    else       rpt_cnt_q <= rpt_cnt_d;
  end
`endif

endmodule

// File: tb/tb_time_set_editor.sv
// Scoreboard bench for time_set_editor: a behavioural model queues the
// expected outputs each cycle; the checker pops and compares on the falling edge.
module tb_time_set_editor;

  localparam int unsigned RD = 8;
  localparam int unsigned RR = 4;
  localparam int unsigned BH = 4;

  logic       clk, reset, edit_en, inc, dec, load;
  logic [2:0] sel, blank;
  logic [4:0] cur_h, set_h;
  logic [5:0] cur_m, cur_s, set_m, set_s;

  time_set_editor #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR), .BLINK_HALF(BH)) dut (
    .clk(clk), .reset(reset), .sel(sel), .edit_en(edit_en), .inc(inc), .dec(dec),
    .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s),
    .set_h(set_h), .set_m(set_m), .set_s(set_s), .blank(blank), .load(load)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [20:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int   m_h, m_m, m_s, m_len, m_age;
  bit   m_active, m_dir, m_dark, e_prev, i_prev, d_prev, m_load;
  logic [2:0] m_blank;

  function automatic int wrap(input int v, input int maxv, input bit down);
    return down ? (v + maxv) % (maxv + 1) : (v + 1) % (maxv + 1);
  endfunction

  task automatic model_step();
    bit step, rise, fall, applied, valid, held;
    step  = 0;
    valid = (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
    if (reset) begin
      m_h = 0; m_m = 0; m_s = 0; m_blank = 3'b000; m_load = 0;
      m_active = 0; m_dir = 0; m_len = 0; m_age = 0; m_dark = 0;
      e_prev = 0; i_prev = 0; d_prev = 0;
    end else begin
      rise = edit_en && !e_prev;
      fall = !edit_en && e_prev;
      if (!edit_en) m_active = 0;
      else if (!m_active) begin
        if (inc && !i_prev && !dec) begin m_active = 1; m_dir = 0; m_len = 0; step = 1; end
        else if (dec && !d_prev && !inc) begin m_active = 1; m_dir = 1; m_len = 0; step = 1; end
      end else begin
        held = m_dir ? dec : inc;
        if (!held || (inc && dec)) m_active = 0;
        else begin
          m_len = m_len + 1;
`ifdef TIME_SET_AUTOREPEAT_EN
          if (m_len >= int'(RD) && (m_len - int'(RD)) % int'(RR) == 0) step = 1;
`endif
        end
      end
      applied = step && edit_en && valid && !rise;
      if (rise) begin
        m_h = int'(cur_h); m_m = int'(cur_m); m_s = int'(cur_s);
      end else if (applied) begin
        if (sel == 3'b001) m_h = wrap(m_h, 23, m_dir);
        if (sel == 3'b010) m_m = wrap(m_m, 59, m_dir);
        if (sel == 3'b100) m_s = wrap(m_s, 59, m_dir);
      end
      if (!edit_en || applied) begin
        m_age = 0; m_dark = 0;
      end else begin
        m_age = m_age + 1;
        if (m_age == int'(BH)) begin m_age = 0; m_dark = !m_dark; end
      end
      m_blank = (edit_en && m_dark && valid) ? sel : 3'b000;
      m_load  = fall;
      e_prev = edit_en; i_prev = inc; d_prev = dec;
    end
    exp_q.push_back({5'(m_h), 6'(m_m), 6'(m_s), m_blank, m_load});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic sb_pop();
    logic [20:0] e, a;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    a = {set_h, set_m, set_s, blank, load};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL scoreboard t=%0t got h=%0d m=%0d s=%0d blank=%b load=%b want h=%0d m=%0d s=%0d blank=%b load=%b",
               $time, a[20:16], a[15:10], a[9:4], a[3:1], a[0], e[20:16], e[15:10], e[9:4], e[3:1], e[0]);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      sb_pop();
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic enter_edit(input int h, input int m, input int s);
    edit_en = 1'b0;
    cyc(2);
    cur_h = 5'(h); cur_m = 6'(m); cur_s = 6'(s);
    edit_en = 1'b1;
    cyc(1);
  endtask

  task automatic press(input bit is_dec, input int n);
    if (is_dec) dec = 1'b1; else inc = 1'b1;
    cyc(n);
    inc = 1'b0; dec = 1'b0;
    cyc(2);
  endtask

  int exp_m;
  int r;

  initial begin
    reset = 1'b1; edit_en = 1'b0; inc = 1'b0; dec = 1'b0; sel = 3'b010;
    cur_h = '0; cur_m = '0; cur_s = '0;
    cyc(3);
    check("reset_set_h", int'(set_h), 0);
    check("reset_blank", int'(blank), 0);
    check("reset_load", int'(load), 0);
    reset = 1'b0;
    cyc(2);

    // Capture on entry, load on exit
    cur_h = 5'd12; cur_m = 6'd34; cur_s = 6'd56; edit_en = 1'b1;
    cyc(1);
    check("capture_h", int'(set_h), 12);
    check("capture_m", int'(set_m), 34);
    check("capture_s", int'(set_s), 56);
    cur_h = 5'd1; cur_m = 6'd2; cur_s = 6'd3;
    edit_en = 1'b0;
    cyc(1);
    check("load_pulse", int'(load), 1);
    check("load_hold_h", int'(set_h), 12);
    cyc(1);
    check("load_one_cycle", int'(load), 0);
    check("load_hold_s", int'(set_s), 56);

    // Wrap rules
    enter_edit(23, 5, 7);
    sel = 3'b001;
    press(0, 1);
    check("hr_wrap_up", int'(set_h), 0);
    check("hr_wrap_m", int'(set_m), 5);
    check("hr_wrap_s", int'(set_s), 7);
    press(1, 1);
    check("hr_wrap_down", int'(set_h), 23);
    enter_edit(1, 0, 59);
    sel = 3'b010;
    press(1, 1);
    check("min_wrap_down", int'(set_m), 59);
    sel = 3'b100;
    press(0, 1);
    check("sec_wrap_up", int'(set_s), 0);
    check("sec_wrap_m", int'(set_m), 59);

    // Held button
    enter_edit(0, 10, 0);
    sel = 3'b010;
    press(0, 20);
`ifdef TIME_SET_AUTOREPEAT_EN
    exp_m = 14;
`else
    exp_m = 11;
`endif
    check("hold_20", int'(set_m), exp_m);

    // Simultaneous buttons and invalid select
    inc = 1'b1; dec = 1'b1;
    cyc(3);
    inc = 1'b0; dec = 1'b0;
    cyc(2);
    check("both_buttons", int'(set_m), exp_m);
    sel = 3'b011; inc = 1'b1;
    cyc(2);
    check("bad_sel_blank", int'(blank), 0);
    inc = 1'b0;
    cyc(1);
    check("bad_sel_m", int'(set_m), exp_m);

    // Blink, then a step forces visible
    sel = 3'b010;
    cyc(12);
    for (int i = 0; i < 10 && blank != 3'b010; i++) cyc(1);
    check("blink_dark", int'(blank), 2);
    inc = 1'b1;
    cyc(1);
    check("step_unblank", int'(blank), 0);
    check("step_value", int'(set_m), (exp_m + 1) % 60);

    // Reset mid-hold
    cyc(3);
    reset = 1'b1;
    cyc(1);
    check("rst_h", int'(set_h), 0);
    check("rst_m", int'(set_m), 0);
    check("rst_blank", int'(blank), 0);
    check("rst_load", int'(load), 0);
    inc = 1'b0;
    cyc(1);
    reset = 1'b0;
    cyc(2);
    check("rst_no_load", int'(load), 0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 11) == 0) inc = ~inc;
      if ($urandom_range(0, 15) == 0) dec = ~dec;
      if ($urandom_range(0, 59) == 0) edit_en = ~edit_en;
      if ($urandom_range(0, 19) == 0) begin
        r = int'($urandom_range(0, 5));
        case (r)
          0: sel = 3'b001;
          1: sel = 3'b010;
          2: sel = 3'b100;
          3: sel = 3'b011;
          4: sel = 3'b000;
          default: sel = 3'b010;
        endcase
      end
      reset = ($urandom_range(0, 399) == 0);
      cur_h = 5'($urandom_range(0, 23));
      cur_m = 6'($urandom_range(0, 59));
      cur_s = 6'($urandom_range(0, 59));
      cyc(1);
    end
    reset = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_set_editor.md
Name: time_set_editor

Overview:
- Edits the HH:MM:SS value of the clock while the user is in set mode.
- Consumes the one-hot field select (001 = hours, 010 = minutes, 100 = seconds) and increment/decrement buttons, and edits the selected field with wrap-around.
- Drives a per-field blink mask for the display.
- When set mode exits, emits a one-cycle load strobe to the timekeeping counter.

Parameters:
- REPEAT_DELAY, 50_000_000: cycles a button must be held before auto-repeat starts.
- REPEAT_RATE, 10_000_000: cycles between auto-repeat steps.
- BLINK_HALF, 25_000_000: cycles per blink half-period.

Ports:
- clk  in  1  system clock; all logic on posedge clk.
- reset  in  1  synchronous, active-high reset.
- sel  in  3  one-hot field select: 001 hours, 010 minutes, 100 seconds.
- edit_en  in  1  level; high = set mode.
- inc  in  1  increment button level, already synchronized/debounced.
- dec  in  1  decrement button level, already synchronized/debounced.
- cur_h  in  5  running hours, 0..23.
- cur_m  in  6  running minutes, 0..59.
- cur_s  in  6  running seconds, 0..59.
- set_h  out  5  edited hours.
- set_m  out  6  edited minutes.
- set_s  out  6  edited seconds.
- blank  out  3  one-hot blank mask, aligned to sel; 1 = digit pair dark.
- load  out  1  one-cycle pulse: running clock loads set_h/m/s.

Behaviour:
- Clock and reset:
  - Single clock domain; reset is synchronous and active-high, sampled on posedge clk.
  - Reset values: set_h = 0, set_m = 0, set_s = 0, blank = 000, load = 0, button FSM = IDLE, blink counter = 0, blink phase = visible.
- Capture and load:
  - On the cycle edit_en rises (0→1, registered edge detect), set_h/m/s capture cur_h/m/s.
  - On the cycle edit_en falls, load = 1 for exactly one cycle; set_h/m/s hold their values.
- Step conditions:
  - Steps are applied only while edit_en = 1 and sel is exactly one of 001/010/100.
  - Any other sel value: no edits, blank = 000.
- Wrap rules:
  - Hours: 23 + 1 → 0; 0 − 1 → 23.
  - Minutes and seconds: 59 + 1 → 0; 0 − 1 → 59.
  - A step changes only the selected field; no carry or borrow into other fields.
- Button FSM (states IDLE, HOLD, REPEAT):
  - IDLE: on a rising edge of exactly one of inc/dec, apply one step the next cycle; latch the direction; go to HOLD; clear the hold counter.
  - HOLD: latched button still high → count. At REPEAT_DELAY−1, apply one step and go to REPEAT. Button released → IDLE.
  - REPEAT: one step every REPEAT_RATE cycles while the button is held. Release → IDLE.
  - inc and dec both high in the same cycle: no step. From HOLD or REPEAT, go to IDLE.
  - Rising edge of the opposite button while in HOLD or REPEAT: ignored until both are released.
  - edit_en = 0 forces IDLE.
- sel change mid-hold: the FSM continues, and later steps apply to the newly selected field.
- Blink:
  - While edit_en = 1, the blink counter runs and the phase toggles every BLINK_HALF cycles.
  - blank = sel during the dark phase, 000 otherwise.
  - Any applied step resets the counter and forces the visible phase, so the edited value is visible immediately.
- Step latency: one cycle from the registered edge to the updated set_* output.
- edit_en 0→1 coinciding with a button edge: capture takes priority; the step is dropped.
- Reset mid-edit: all state returns to reset values; no load pulse.

Optional Feature:
- Macro: TIME_SET_AUTOREPEAT_EN.
- Defined: HOLD/REPEAT behaviour as above.
- Undefined:
  - The FSM collapses to IDLE/HOLD with no timed steps: exactly one step per press; release returns to IDLE.
  - REPEAT_DELAY and REPEAT_RATE are unused, and their counters are not instantiated.

Decomposition:
- Shared package:
  - Field select constants SEL_HR = 3'b001, SEL_MIN = 3'b010, SEL_SEC = 3'b100. These match the existing field-select encoding.
  - Limits HR_MAX = 23 and MS_MAX = 59.
  - Button FSM state encoding.
- Sub-module field_step: combinational value/limit/up/down → wrapped value, instantiated per field.

Test Plan:
- Capture and load: cur = 12:34:56, edit_en 0→1 → set = 12:34:56 next cycle. edit_en 1→0 → load high for exactly one cycle, set unchanged.
- Hours wrap: sel = 001, set_h = 23, press inc → set_h = 0, set_m/set_s unchanged. Press dec → 23.
- Minutes/seconds wrap: sel = 010 with set_m = 0, dec → 59. sel = 100 with set_s = 59, inc → 0.
- Auto-repeat, with REPEAT_DELAY = 8 and REPEAT_RATE = 4 in the bench:
  - Hold inc for 20 cycles on minutes starting at 10.
  - Macro defined → 10→11 at press, →12 after delay, then +1 every 4 cycles, final value 14.
  - Macro undefined → 11.
- Invalid input:
  - inc and dec rise in the same cycle → no change.
  - sel = 011 with inc pressed → no change, blank = 000.
- Blink and reset, with BLINK_HALF = 4:
  - sel = 010 → blank alternates 010/000 every 4 cycles.
  - A step forces blank = 000.
  - Reset mid-hold → all outputs 0 next cycle, no load pulse.
